// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch
// Function : Instruction fetch with a prefetch buffer, branch redirect and
//            squashing of an outstanding request.
// Revision : 1.0  initial release
// ============================================================================
module if_prefetch #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 10,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          freez,
    input  logic                          pause,
    input  logic                          br_taken,
    input  logic [DATA_W-1:0]             br_addr,
    output logic                          imem_req,
    output logic [ADDR_W-1:0]             imem_addr,
    input  logic                          imem_ack,
    input  logic [DATA_W-1:0]             imem_rdata,
    output logic [DATA_W-1:0]             pc_out,
    output logic [DATA_W-1:0]             instr_out,
    output logic                          instr_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int               c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_FULL       = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [0:0]       c_ST_FETCH   = 1'b0;
    localparam logic [0:0]       c_ST_DISCARD = 1'b1;

    logic [0:0]         r_state;
    logic [DATA_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_hold_addr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [DATA_W-1:0]  r_pc_mem    [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_instr_mem [FIFO_DEPTH];

    logic               w_discard;
    logic               w_req;
    logic               w_ack;
    logic               w_push;
    logic               w_upd;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_fetch_addr;

    // The request only rises while there is room, and the count cannot grow
    // without an ack, so req/addr stay stable until the ack arrives.
    assign w_discard    = (r_state == c_ST_DISCARD);
    assign w_fetch_addr = r_fetch_pc[ADDR_W+1:2];
    assign w_req        = ~rst & (w_discard | (r_count < c_FULL));
    assign w_ack        = imem_ack & w_req;
    assign w_push       = w_ack & ~w_discard & ~br_taken;
    assign w_upd        = ~freez & ~pause & ~br_taken;
    assign w_pop        = w_upd & (r_count != '0);

    assign imem_req     = w_req;
    assign imem_addr    = w_discard ? r_hold_addr : w_fetch_addr;
    assign fifo_count   = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_FETCH;
            r_fetch_pc  <= RESET_PC;
            r_hold_addr <= '0;
        end else begin
            if (br_taken) begin
                r_fetch_pc <= br_addr;
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + DATA_W'(4);
            end

            // A redirect that catches a request in flight must keep driving
            // the old address until the memory answers, then drop that data.
            if (w_discard) begin
                if (imem_ack) begin
                    r_state <= c_ST_FETCH;
                end
            end else if (br_taken && w_req && !imem_ack) begin
                r_state     <= c_ST_DISCARD;
                r_hold_addr <= w_fetch_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (br_taken) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_PTR_W+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (c_PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
            r_instr_mem[r_wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out      <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
        end else if (br_taken) begin
            instr_out   <= '0;
            instr_valid <= 1'b0;
        end else if (w_upd) begin
            if (w_pop) begin
                pc_out      <= r_pc_mem[r_rd_ptr] + DATA_W'(4);
                instr_out   <= r_instr_mem[r_rd_ptr];
                instr_valid <= 1'b1;
            end else begin
                instr_out   <= '0;
                instr_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch
// Function : Self-checking bench for if_prefetch: latency-randomised memory
//            and an instruction-stream scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_prefetch;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freez = 1'b0;
    logic        pause = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_addr = 32'h0;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [2:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;
    int lat_min = 0;
    int lat_max = 0;
    int m_lat = 0;
    int m_cnt = 0;
    logic [31:0] exp_pc = RESET_PC;

    if_prefetch #(
        .DATA_W     (32),
        .ADDR_W     (10),
        .FIFO_DEPTH (4),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freez       (freez),
        .pause       (pause),
        .br_taken    (br_taken),
        .br_addr     (br_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    // Memory: answers each request after m_lat waiting cycles (0 = same cycle).
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            imem_ack = 1'b0;
            m_cnt    = 0;
            m_lat    = $urandom_range(lat_max, lat_min);
        end else begin
            if (imem_ack) begin
                m_cnt = 0;
                m_lat = $urandom_range(lat_max, lat_min);
            end
            if (imem_req && m_cnt >= m_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                m_cnt      = imem_req ? m_cnt + 1 : 0;
            end
        end
    end

    // Scoreboard: issued instructions must be the consecutive words starting
    // at the last redirect target; stalls hold the output register.
    always @(posedge clk) begin : mon
        logic        s_rst, s_br, s_upd, s_req, s_ack, p_valid;
        logic [31:0] s_baddr, p_pc, p_instr;
        logic [9:0]  s_addr;
        s_rst   = rst;
        s_br    = br_taken;
        s_upd   = !freez && !pause && !br_taken;
        s_req   = imem_req;
        s_ack   = imem_ack;
        s_addr  = imem_addr;
        s_baddr = br_addr;
        p_pc    = pc_out;
        p_instr = instr_out;
        p_valid = instr_valid;
        #1;
        if (s_rst || rst) begin
            exp_pc = RESET_PC;
        end else begin
            if (s_req && !s_ack) begin
                n_vec++;
                if (imem_req !== 1'b1 || imem_addr !== s_addr) begin
                    n_err++;
                    $display("FAIL req_stable: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, s_addr);
                end
            end
            n_vec++;
            if (fifo_count > 3'd4) begin
                n_err++;
                $display("FAIL fifo_bound: count=%0d, required <=4", fifo_count);
            end
            if (s_br) begin
                exp_pc = s_baddr;
                n_vec++;
                if (instr_valid !== 1'b0 || instr_out !== 32'h0) begin
                    n_err++;
                    $display("FAIL redirect_bubble: valid=%b instr=%h, required 0/0", instr_valid, instr_out);
                end
            end else if (s_upd) begin
                n_vec++;
                if (instr_valid === 1'b1) begin
                    if (pc_out !== exp_pc + 32'd4 || instr_out !== mem_word(exp_pc[11:2])) begin
                        n_err++;
                        $display("FAIL issue_order: pc=%h instr=%h, required pc=%h instr=%h",
                                 pc_out, instr_out, exp_pc + 32'd4, mem_word(exp_pc[11:2]));
                    end
                    exp_pc = exp_pc + 32'd4;
                end else if (instr_out !== 32'h0 || pc_out !== p_pc) begin
                    n_err++;
                    $display("FAIL empty_bubble: pc=%h instr=%h, required pc=%h instr=0", pc_out, instr_out, p_pc);
                end
            end else begin
                n_vec++;
                if (pc_out !== p_pc || instr_out !== p_instr || instr_valid !== p_valid) begin
                    n_err++;
                    $display("FAIL stall_hold: pc=%h instr=%h v=%b, required pc=%h instr=%h v=%b",
                             pc_out, instr_out, instr_valid, p_pc, p_instr, p_valid);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; freez = 1'b0; pause = 1'b0; br_taken = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (imem_req !== 1'b0 || pc_out !== 32'h0 || instr_out !== 32'h0 ||
            instr_valid !== 1'b0 || fifo_count !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: req=%b pc=%h instr=%h v=%b cnt=%0d, required all 0",
                     imem_req, pc_out, instr_out, instr_valid, fifo_count);
        end
    endtask

    task automatic test_zero_wait();
        lat_min = 0; lat_max = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (k == 1) begin
                if (instr_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL zero_wait_edge1: valid=%b, required 0", instr_valid);
                end
            end else if (instr_valid !== 1'b1 || pc_out !== 32'(4 * (k - 1)) ||
                         instr_out !== mem_word(10'(k - 2))) begin
                n_err++;
                $display("FAIL zero_wait_edge%0d: v=%b pc=%h instr=%h, required v=1 pc=%h instr=%h",
                         k, instr_valid, pc_out, instr_out, 32'(4 * (k - 1)), mem_word(10'(k - 2)));
            end
        end
    endtask

    task automatic test_freeze();
        logic [31:0] pc0;
        @(negedge clk);
        freez = 1'b1;
        repeat (10) @(negedge clk);
        n_vec++;
        if (fifo_count !== 3'd4 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL freeze_full: cnt=%0d req=%b, required cnt=4 req=0", fifo_count, imem_req);
        end
        pc0 = pc_out;
        freez = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (instr_valid !== 1'b1 || pc_out !== pc0 + 32'(4 * k)) begin
                n_err++;
                $display("FAIL freeze_drain%0d: v=%b pc=%h, required v=1 pc=%h", k, instr_valid, pc_out, pc0 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_discard();
        bit got = 1'b0;
        lat_min = 3; lat_max = 3;
        do_reset();
        @(negedge clk);
        br_taken = 1'b1; br_addr = 32'h80;
        @(posedge clk);
        #1;
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h0) begin
            n_err++;
            $display("FAIL discard_hold: req=%b addr=%h, required req=1 addr=000", imem_req, imem_addr);
        end
        @(negedge clk);
        br_taken = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            if (imem_ack) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        n_vec++;
        if (!got || imem_addr !== 10'h20 || fifo_count !== 3'd0 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL discard_return: ack_seen=%b addr=%h cnt=%0d v=%b, required 1/020/0/0",
                     got, imem_addr, fifo_count, instr_valid);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_br_ack_pause();
        logic [31:0] tgt;
        bit          hit;
        lat_min = 0; lat_max = 0;
        repeat (6) @(negedge clk);
        pause = 1'b1;
        repeat (2) @(negedge clk);
        tgt = 32'($urandom_range(1023, 0)) << 2;
        br_taken = 1'b1; br_addr = tgt;
        @(posedge clk);
        hit = imem_req && imem_ack;
        #1;
        n_vec++;
        if (!hit || instr_out !== 32'h0 || instr_valid !== 1'b0 || fifo_count !== 3'd0 ||
            imem_addr !== tgt[11:2]) begin
            n_err++;
            $display("FAIL br_ack_pause: req_ack=%b instr=%h v=%b cnt=%0d addr=%h, required 1/0/0/0/%h",
                     hit, instr_out, instr_valid, fifo_count, imem_addr, tgt[11:2]);
        end
        @(negedge clk);
        br_taken = 1'b0; pause = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_push_pop();
        bit found = 1'b0;
        lat_min = 0; lat_max = 0;
        @(negedge clk);
        freez = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_count == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        freez = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (!found || fifo_count !== 3'd3 || instr_valid !== 1'b1) begin
                n_err++;
                $display("FAIL push_pop%0d: reached=%b cnt=%0d v=%b, required 1/3/1", k, found, fifo_count, instr_valid);
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        lat_min = 5; lat_max = 5;
        @(negedge clk);
        br_taken = 1'b1; br_addr = 32'h300;
        @(negedge clk);
        br_taken = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr == 10'hC0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (!seen || imem_req !== 1'b0 || pc_out !== 32'h0 || instr_out !== 32'h0 ||
            instr_valid !== 1'b0 || fifo_count !== 3'd0) begin
            n_err++;
            $display("FAIL reset_mid: req_seen=%b req=%b pc=%h instr=%h v=%b cnt=%0d, required 1/0/0/0/0/0",
                     seen, imem_req, pc_out, instr_out, instr_valid, fifo_count);
        end
        @(negedge clk);
        rst = 1'b0;
        #2;
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC[11:2]) begin
            n_err++;
            $display("FAIL reset_restart: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, RESET_PC[11:2]);
        end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_random();
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            freez    = ($urandom_range(3, 0) == 0);
            pause    = ($urandom_range(5, 0) == 0);
            br_taken = ($urandom_range(19, 0) == 0);
            br_addr  = ($urandom_range(3, 0) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                                    : (32'($urandom_range(1023, 0)) << 2);
        end
        @(negedge clk);
        freez = 1'b0; pause = 1'b0; br_taken = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_freeze();
        test_discard();
        test_br_ack_pause();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
